// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and slave FSM state type.
package ahb_lite_pkg;

   localparam int unsigned HADDR_W = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned BE_W    = DATA_W / 8;

   // Transfer type encodings
   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   // Transfer size encodings; anything above word is unsupported
   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   // Response encodings
   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Slave transfer FSM
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MEM  = 3'd1,
      ST_DONE = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } state_e;

   // Lane decode result for one address phase
   typedef struct packed {
      logic            err;
      logic [BE_W-1:0] be;
   } be_info_t;

endpackage

// File: rtl/ahb_be_gen.sv
// Byte-enable generation and alignment check for a single AHB beat.
module ahb_be_gen
   import ahb_lite_pkg::*;
(
   input  logic [2:0] hsize,
   input  logic [1:0] addr_lo,
   output be_info_t   info_c
);

   // Map size and low address bits onto byte lanes; flag unsupported sizes and misalignment
   always_comb begin
      info_c = '0;
      case (hsize)
         HSIZE_BYTE: begin
            info_c.be = BE_W'(4'b0001 << addr_lo);
         end
         HSIZE_HALF: begin
            info_c.be  = addr_lo[1] ? 4'b1100 : 4'b0011;
            info_c.err = addr_lo[0];
         end
         HSIZE_WORD: begin
            info_c.be  = 4'b1111;
            info_c.err = |addr_lo;
         end
         default: begin
            info_c.err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite slave bridging single beats onto a req/ack word memory port.
module ahb_lite_mem_slave
   import ahb_lite_pkg::*;
#(
   parameter int unsigned ADDR_W = 24
)
(
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              hsel,
   input  logic [31:0]       haddr,
   input  logic              hwrite,
   input  logic [1:0]        htrans,
   input  logic [2:0]        hsize,
   input  logic [2:0]        hburst,
   input  logic [31:0]       hwdata,
   input  logic              hready,
   output logic              hreadyout,
   output logic              hresp,
   output logic [31:0]       hrdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   state_e   state;
   state_e   next_state;
   be_info_t be_info;
   logic     accept_c;
   logic     load_c;
   logic     capture_c;
   logic     hreadyout_d;
   logic     hresp_d;
   logic     mem_req_d;
   logic     unused_bits;

   // Bursts are handled beat by beat and the memory only sees a word address
   assign unused_bits = ^{hburst, haddr[HADDR_W-1:ADDR_W+2]};

   ahb_be_gen u_be_gen (
      .hsize   (hsize),
      .addr_lo (haddr[1:0]),
      .info_c  (be_info)
   );

   // Address phase qualifies only when the bus is ready and the transfer is active
   assign accept_c = hsel && hready &&
                     ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

   // Write data is already stable for the whole data phase
   assign mem_wdata = hwdata;

   // Next-state and next-output decode
   always_comb begin
      next_state  = state;
      load_c      = 1'b0;
      capture_c   = 1'b0;
      hreadyout_d = 1'b1;
      hresp_d     = HRESP_OKAY;
      mem_req_d   = 1'b0;

      case (state)
         ST_IDLE, ST_DONE, ST_ERR2: begin
            if (accept_c) begin
               if (be_info.err) begin
                  next_state = ST_ERR1;
               end else begin
                  next_state = ST_MEM;
                  load_c     = 1'b1;
               end
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_MEM: begin
            if (mem_ack) begin
               next_state = ST_DONE;
               capture_c  = !mem_we;
            end
         end
         ST_ERR1: begin
            next_state = ST_ERR2;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase

      case (next_state)
         ST_MEM: begin
            hreadyout_d = 1'b0;
            mem_req_d   = 1'b1;
         end
         ST_ERR1: begin
            hreadyout_d = 1'b0;
            hresp_d     = HRESP_ERROR;
         end
         ST_ERR2: begin
            hresp_d     = HRESP_ERROR;
         end
         default: begin
            hreadyout_d = 1'b1;
         end
      endcase
   end

   // State and handshake outputs, all decoded one cycle ahead
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state     <= ST_IDLE;
         hreadyout <= 1'b1;
         hresp     <= HRESP_OKAY;
         mem_req   <= 1'b0;
      end else begin
         state     <= next_state;
         hreadyout <= hreadyout_d;
         hresp     <= hresp_d;
         mem_req   <= mem_req_d;
      end
   end

   // Request attributes captured at accept and held for the whole request
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_be   <= '0;
      end else if (load_c) begin
         mem_we   <= hwrite;
         mem_addr <= haddr[ADDR_W+1:2];
         mem_be   <= be_info.be;
      end
   end

   // Read data captured on the completing ack and held until the next read
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         hrdata <= '0;
      end else if (capture_c) begin
         hrdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Self-checking bench for ahb_lite_mem_slave: directed table, corner sequences, random vs reference model.
module tb_ahb_lite_mem_slave;

   localparam int unsigned ADDR_W    = 24;
   localparam int unsigned MEM_WORDS = 64;

   logic              hclk = 1'b0;
   logic              hresetn;
   logic              hsel;
   logic [31:0]       haddr;
   logic              hwrite;
   logic [1:0]        htrans;
   logic [2:0]        hsize;
   logic [2:0]        hburst;
   logic [31:0]       hwdata;
   logic              hready;
   logic              hreadyout;
   logic              hresp;
   logic [31:0]       hrdata;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   // Environment controls
   logic        stall;
   logic        ack_en;
   logic        ack_force;
   logic        mem_clear;
   int unsigned ack_delay;

   // Memory device state
   logic [31:0]       dev_mem [MEM_WORDS];
   int unsigned       req_cnt;
   int                hs_cnt;
   logic [ADDR_W-1:0] hs_addr;
   logic [3:0]        hs_be;
   logic              hs_we;
   logic [31:0]       hs_wdata;
   int                stab_viol;
   logic              req_active;
   logic [ADDR_W+4:0] held;

   // Reference model storage
   logic [31:0] ref_mem [MEM_WORDS];

   int checks;
   int errors;

   typedef struct {
      logic [31:0]       addr;
      logic              wr;
      logic [2:0]        size;
      logic [31:0]       wdata;
      int unsigned       dly;
      logic              exp_resp;
      int                exp_waits;
      logic [3:0]        exp_be;
      logic [ADDR_W-1:0] exp_maddr;
      logic [31:0]       exp_rdata;
   } vec_t;

   ahb_lite_mem_slave #(.ADDR_W(ADDR_W)) dut (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .hsel      (hsel),
      .haddr     (haddr),
      .hwrite    (hwrite),
      .htrans    (htrans),
      .hsize     (hsize),
      .hburst    (hburst),
      .hwdata    (hwdata),
      .hready    (hready),
      .hreadyout (hreadyout),
      .hresp     (hresp),
      .hrdata    (hrdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 hclk = ~hclk;

   // Single-slave bus unless another slave is stalling it
   assign hready    = stall ? 1'b0 : hreadyout;
   assign mem_ack   = ack_force || (mem_req && ack_en && (req_cnt >= ack_delay));
   assign mem_rdata = dev_mem[mem_addr[5:0]];

   // Memory device: delayed ack, lane writes, handshake log, request stability monitor
   always @(posedge hclk) begin
      if (mem_clear) begin
         for (int i = 0; i < MEM_WORDS; i++) dev_mem[i] <= '0;
      end
      if (mem_req && !mem_ack) req_cnt <= req_cnt + 1;
      else                     req_cnt <= 0;
      if (mem_req && mem_ack) begin
         hs_cnt   <= hs_cnt + 1;
         hs_addr  <= mem_addr;
         hs_be    <= mem_be;
         hs_we    <= mem_we;
         hs_wdata <= mem_wdata;
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) dev_mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
      if (mem_req) begin
         if (req_active && (held != {mem_addr, mem_be, mem_we})) stab_viol <= stab_viol + 1;
         held       <= {mem_addr, mem_be, mem_we};
         req_active <= !mem_ack;
      end else begin
         req_active <= 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [2:0] sz,
                               input logic [31:0] wd, input int unsigned dly, input logic er,
                               input int wt, input logic [3:0] be, input logic [ADDR_W-1:0] ma,
                               input logic [31:0] rd);
      vec_t v;
      v.addr = a;  v.wr = w;  v.size = sz;  v.wdata = wd;  v.dly = dly;
      v.exp_resp = er;  v.exp_waits = wt;  v.exp_be = be;  v.exp_maddr = ma;  v.exp_rdata = rd;
      return v;
   endfunction

   // Reference model: expected outcome of one transfer from the protocol rules
   function automatic vec_t model(input logic [31:0] a, input logic w, input logic [2:0] sz,
                                  input logic [31:0] wd, input int unsigned dly);
      vec_t        v;
      int unsigned sz_i;
      int unsigned a_i;
      sz_i = 32'(sz);
      a_i  = a;
      v.addr = a;  v.wr = w;  v.size = sz;  v.wdata = wd;  v.dly = dly;
      v.exp_resp = (sz_i > 2) || (sz_i == 1 && (a_i % 2) != 0) || (sz_i == 2 && (a_i % 4) != 0);
      if (sz_i == 0)      v.exp_be = 4'(1 << (a_i % 4));
      else if (sz_i == 1) v.exp_be = 4'(3 << (a_i & 2));
      else                v.exp_be = 4'hF;
      v.exp_maddr = ADDR_W'(a_i / 4);
      v.exp_waits = v.exp_resp ? 1 : 1 + int'(dly);
      v.exp_rdata = ref_mem[(a_i / 4) % MEM_WORDS];
      return v;
   endfunction

   function automatic void ref_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      int unsigned w;
      w = (a / 4) % MEM_WORDS;
      for (int b = 0; b < 4; b++)
         if (be[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
   endfunction

   // One non-pipelined transfer: address phase, then data phase until hreadyout
   task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [31:0] wd, input int unsigned dly,
                       output logic [31:0] rd, output logic resp, output logic wait_resp,
                       output int waits);
      ack_delay = dly;
      hsel   = 1'b1;
      haddr  = a;
      hwrite = w;
      hsize  = sz;
      htrans = 2'd2;
      hburst = 3'($urandom_range(0, 7));
      @(posedge hclk); #1;
      hsel   = 1'b0;
      htrans = 2'd0;
      haddr  = $urandom;
      hwrite = 1'($urandom_range(0, 1));
      hsize  = 3'($urandom_range(0, 7));
      hwdata = wd;
      waits = 0;  wait_resp = 1'b0;  rd = '0;  resp = 1'b0;
      for (int c = 0; c < 64; c++) begin
         @(negedge hclk);
         if (hreadyout) begin
            rd   = hrdata;
            resp = hresp;
            break;
         end
         waits++;
         wait_resp = wait_resp | hresp;
      end
      @(posedge hclk); #1;
   endtask

   task automatic apply_vec(input vec_t v, input string tag);
      int          hs0;
      logic [31:0] rd;
      logic        resp;
      logic        wresp;
      int          waits;
      hs0 = hs_cnt;
      xfer(v.addr, v.wr, v.size, v.wdata, v.dly, rd, resp, wresp, waits);
      chk({tag, " hresp"}, 32'(resp), 32'(v.exp_resp));
      chk({tag, " waits"}, 32'(waits), 32'(v.exp_waits));
      chk({tag, " wait_hresp"}, 32'(wresp), 32'(v.exp_resp));
      if (v.exp_resp) begin
         chk({tag, " mem_accesses"}, 32'(hs_cnt - hs0), 32'd0);
      end else begin
         chk({tag, " mem_accesses"}, 32'(hs_cnt - hs0), 32'd1);
         chk({tag, " mem_addr"}, 32'(hs_addr), 32'(v.exp_maddr));
         chk({tag, " mem_be"}, 32'(hs_be), 32'(v.exp_be));
         chk({tag, " mem_we"}, 32'(hs_we), 32'(v.wr));
         if (v.wr) begin
            chk({tag, " mem_wdata"}, hs_wdata, v.wdata);
            ref_write(v.addr, v.exp_be, v.wdata);
         end else begin
            chk({tag, " hrdata"}, rd, v.exp_rdata);
         end
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " hreadyout"}, 32'(hreadyout), 32'd1);
      chk({tag, " hresp"},     32'(hresp),     32'd0);
      chk({tag, " hrdata"},    hrdata,         32'd0);
      chk({tag, " mem_req"},   32'(mem_req),   32'd0);
      chk({tag, " mem_we"},    32'(mem_we),    32'd0);
      chk({tag, " mem_addr"},  32'(mem_addr),  32'd0);
      chk({tag, " mem_be"},    32'(mem_be),    32'd0);
   endtask

   initial begin
      vec_t        tbl [$];
      logic        pat [$];
      logic [3:0]  exp_pat;
      logic        r1, r2, done;
      logic [31:0] rd;
      int          hs0;

      checks = 0;  errors = 0;
      hresetn = 1'b0;  mem_clear = 1'b1;
      stall = 1'b0;  ack_en = 1'b1;  ack_force = 1'b0;  ack_delay = 0;
      hsel = 1'b0;  haddr = '0;  hwrite = 1'b0;  htrans = 2'd0;  hsize = 3'd0;
      hburst = 3'd0;  hwdata = '0;
      for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = '0;

      // Reset state
      repeat (3) @(posedge hclk);
      @(negedge hclk);
      chk_reset("reset");
      #2 hresetn = 1'b1;
      @(posedge hclk); #1;
      mem_clear = 1'b0;

      // Directed vectors: {addr, wr, size, wdata, ack_dly, resp, waits, be, mem_addr, rdata}
      tbl.push_back(mk(32'h10,       1'b1, 3'd2, 32'hDEADBEEF, 2, 1'b0, 3, 4'hF,    24'h4,  32'h0));
      tbl.push_back(mk(32'h10,       1'b0, 3'd2, 32'h0,        1, 1'b0, 2, 4'hF,    24'h4,  32'hDEADBEEF));
      tbl.push_back(mk(32'h10,       1'b1, 3'd2, 32'h11223344, 0, 1'b0, 1, 4'hF,    24'h4,  32'h0));
      tbl.push_back(mk(32'h13,       1'b0, 3'd0, 32'h0,        0, 1'b0, 1, 4'b1000, 24'h4,  32'h11223344));
      tbl.push_back(mk(32'h2,        1'b0, 3'd2, 32'h0,        0, 1'b1, 1, 4'h0,    24'h0,  32'h0));
      tbl.push_back(mk(32'h6,        1'b1, 3'd1, 32'hBEEF0000, 1, 1'b0, 2, 4'b1100, 24'h1,  32'h0));
      tbl.push_back(mk(32'h5,        1'b0, 3'd1, 32'h0,        0, 1'b1, 1, 4'h0,    24'h0,  32'h0));
      tbl.push_back(mk(32'h0,        1'b0, 3'd3, 32'h0,        0, 1'b1, 1, 4'h0,    24'h0,  32'h0));
      tbl.push_back(mk(32'h21,       1'b1, 3'd0, 32'h0000AB00, 0, 1'b0, 1, 4'b0010, 24'h8,  32'h0));
      tbl.push_back(mk(32'h20,       1'b0, 3'd2, 32'h0,        3, 1'b0, 4, 4'hF,    24'h8,  32'h0000AB00));
      tbl.push_back(mk(32'h102,      1'b1, 3'd1, 32'hCAFE0000, 0, 1'b0, 1, 4'b1100, 24'h40, 32'h0));
      tbl.push_back(mk(32'hF0000044, 1'b1, 3'd2, 32'h12345678, 0, 1'b0, 1, 4'hF,    24'h11, 32'h0));
      tbl.push_back(mk(32'hF0000044, 1'b0, 3'd2, 32'h0,        1, 1'b0, 2, 4'hF,    24'h11, 32'h12345678));
      tbl.push_back(mk(32'h6,        1'b0, 3'd1, 32'h0,        0, 1'b0, 1, 4'b1100, 24'h1,  32'hBEEF0000));
      tbl.push_back(mk(32'h7,        1'b1, 3'd7, 32'h55555555, 0, 1'b1, 1, 4'h0,    24'h0,  32'h0));
      foreach (tbl[i]) apply_vec(tbl[i], $sformatf("vec%0d", i));

      // Idle, busy and stalled traffic, with a stray ack while no request is open
      hs0 = hs_cnt;
      ack_force = 1'b1;
      hsel = 1'b1;  haddr = 32'h10;  hsize = 3'd2;  hwrite = 1'b1;
      for (int c = 0; c < 7; c++) begin
         htrans = (c < 2) ? 2'd0 : (c < 4) ? 2'd1 : 2'd2;
         stall  = (c >= 4);
         @(negedge hclk);
         chk($sformatf("idle%0d hreadyout", c), 32'(hreadyout), 32'd1);
         chk($sformatf("idle%0d hresp", c),     32'(hresp),     32'd0);
         chk($sformatf("idle%0d mem_req", c),   32'(mem_req),   32'd0);
         @(posedge hclk); #1;
      end
      hsel = 1'b0;  htrans = 2'd0;  stall = 1'b0;  ack_force = 1'b0;
      chk("idle mem_accesses", 32'(hs_cnt - hs0), 32'd0);
      apply_vec(model(32'h10, 1'b0, 3'd2, 32'h0, 2), "after_idle");

      // Back-to-back: write 0x0 then read 0x4 with the second address taken in DONE
      apply_vec(model(32'h4, 1'b1, 3'd2, 32'h5A5A0001, 0), "b2b_pre");
      ack_delay = 0;  hs0 = hs_cnt;  r1 = 1'b1;  r2 = 1'b1;  rd = '0;
      hsel = 1'b1;  haddr = 32'h0;  hwrite = 1'b1;  hsize = 3'd2;  htrans = 2'd2;
      @(posedge hclk); #1;
      hwdata = 32'h0BADF00D;  haddr = 32'h4;  hwrite = 1'b0;  hsize = 3'd2;  htrans = 2'd2;
      done = 1'b0;
      for (int c = 0; c < 16 && !done; c++) begin
         @(negedge hclk);
         pat.push_back(mem_req);
         if (hreadyout) begin r1 = hresp; done = 1'b1; end
      end
      @(posedge hclk); #1;
      hsel = 1'b0;  htrans = 2'd0;  hwdata = '0;
      done = 1'b0;
      for (int c = 0; c < 16 && !done; c++) begin
         @(negedge hclk);
         pat.push_back(mem_req);
         if (hreadyout) begin r2 = hresp; rd = hrdata; done = 1'b1; end
      end
      @(posedge hclk); #1;
      exp_pat = 4'b0101;
      chk("b2b cycles", 32'(pat.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("b2b mem_req[%0d]", i), 32'((i < pat.size()) ? pat[i] : 1'bx), 32'(exp_pat[i]));
      chk("b2b resp1", 32'(r1), 32'd0);
      chk("b2b resp2", 32'(r2), 32'd0);
      chk("b2b hrdata", rd, 32'h5A5A0001);
      chk("b2b mem_accesses", 32'(hs_cnt - hs0), 32'd2);
      ref_write(32'h0, 4'hF, 32'h0BADF00D);
      apply_vec(model(32'h0, 1'b0, 3'd2, 32'h0, 1), "b2b_post");

      // Reset during an outstanding request
      ack_en = 1'b0;
      hsel = 1'b1;  haddr = 32'h30;  hwrite = 1'b1;  hsize = 3'd2;  htrans = 2'd2;
      @(posedge hclk); #1;
      hsel = 1'b0;  htrans = 2'd0;  hwdata = 32'h77777777;
      @(negedge hclk);
      chk("rst_mid req_open", 32'(mem_req), 32'd1);
      @(negedge hclk);
      chk("rst_mid waiting", 32'(hreadyout), 32'd0);
      #2 hresetn = 1'b0;
      #1 chk_reset("rst_mid");
      @(negedge hclk);
      #2 hresetn = 1'b1;
      ack_en = 1'b1;
      @(posedge hclk); #1;
      apply_vec(model(32'h30, 1'b0, 3'd2, 32'h0, 1), "rst_after_rd");
      apply_vec(model(32'h30, 1'b1, 3'd2, 32'hA5A5C3C3, 0), "rst_after_wr");

      // Randomized transfers against the reference model
      for (int n = 0; n < 200; n++) begin
         logic [31:0] a;
         logic [2:0]  sz;
         a = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFC000000);
         sz = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
         apply_vec(model(a, 1'($urandom_range(0, 1)), sz, $urandom, $urandom_range(0, 3)),
                   $sformatf("rnd%0d", n));
      end

      chk("mem_side stability", 32'(stab_viol), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
